cofre_code_tx: RTL and testbench

- Transmitter side of the vault-lock symbol interface. Drives the 2-bit combination symbols that the lock FSM consumes.
- Takes a packed combination and emits one symbol per slot, each followed by idle (00) gap cycles. Then watches the lock's unlock output and reports pass or fail.
- Sits between the test/control logic and the lock. Used for automated unlock and for lock verification.

---
 rtl/cofre_pkg.sv | 29 ++
 rtl/cofre_tick_cnt.sv | 31 +++
 rtl/cofre_code_tx.sv | 195 +++++++++++++++++++
 tb/tb_cofre_code_tx.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cofre_pkg.sv
// Shared definitions for the vault-lock symbol interface.
//   - sym_t and the symbol constants on the 2-bit lock bus.
//   - tx_state_t: the transmitter FSM states.
//   - DEFAULT_CODE: the factory combination A C A A B (symbol 0 in the low bits).
//   - max_int: elaboration helper used to size counters.
package cofre_pkg;

  typedef logic [1:0] sym_t;

  localparam sym_t SYM_IDLE = 2'b00;
  localparam sym_t SYM_A    = 2'b01;
  localparam sym_t SYM_B    = 2'b10;
  localparam sym_t SYM_C    = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_GAP,
    ST_WAIT,
    ST_DONE
  } tx_state_t;

  localparam logic [9:0] DEFAULT_CODE = 10'h25D;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/cofre_tick_cnt.sv
// Loadable down-counter with a zero flag. Times both the idle gap after
// each symbol and the unlock wait window.
//   clk, rst  : clock, asynchronous active-high reset (count returns to 0)
//   load      : load load_val on the next edge (has priority over counting)
//   load_val  : value to load; a load of N gives N+1 cycles until zero is seen
//   zero      : count is zero; the count then holds and never wraps
module cofre_tick_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         zero
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/cofre_code_tx.sv
// Transmitter for the vault-lock symbol interface. Sends a packed
// combination one symbol per slot, each followed by GAP_CYC idle cycles,
// then watches the lock's unlock output and reports pass/fail.
//
// Optional feature: define COFRE_CODE_TX_ABORT_EN to add the abort input.
//
// Ports:
//   clk       : clock, all state on the rising edge
//   rst       : asynchronous active-high reset
//   abort     : (COFRE_CODE_TX_ABORT_EN only) cancel a run, result ok=0
//   start     : one-cycle request, accepted only in IDLE
//   code_in   : combination, symbol k at bits [2k+1:2k], latched on accept
//   y_in      : unlock indication from the lock
//   x_out     : symbol bus to the lock
//   busy      : run in progress (SEND/GAP/WAIT)
//   done      : one-cycle completion pulse
//   ok        : run result, valid from done until the next accepted start
//   state_dbg : current FSM state
//
// Handshake: start has no ready; a start is taken only on a cycle where the
// FSM is in IDLE (busy=0 and done=0). Starts at any other time are dropped
// and code_in is not re-latched.
module cofre_code_tx
  import cofre_pkg::*;
#(
  parameter int SEQ_LEN = 5,
  parameter int GAP_CYC = 1,
  parameter int TIMEOUT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef COFRE_CODE_TX_ABORT_EN
  input  logic                 abort,
`endif
  input  logic                 start,
  input  logic [2*SEQ_LEN-1:0] code_in,
  input  logic                 y_in,
  output sym_t                 x_out,
  output logic                 busy,
  output logic                 done,
  output logic                 ok,
  output tx_state_t            state_dbg
);

  localparam int CW = $clog2(max_int(GAP_CYC, TIMEOUT) + 1);
  localparam int IW = (SEQ_LEN > 1) ? $clog2(SEQ_LEN) : 1;

  localparam logic [IW-1:0] LAST      = IW'(SEQ_LEN - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYC - 1);
  localparam logic [CW-1:0] WAIT_LOAD = CW'(TIMEOUT - 1);

  if (SEQ_LEN < 1) begin : g_seq_chk
    $error("cofre_code_tx: SEQ_LEN must be >= 1");
  end
  if (GAP_CYC < 1) begin : g_gap_chk
    $error("cofre_code_tx: GAP_CYC must be >= 1");
  end
  if (TIMEOUT < 1) begin : g_tmo_chk
    $error("cofre_code_tx: TIMEOUT must be >= 1");
  end

  tx_state_t            state_q, state_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [2*SEQ_LEN-1:0] code_q, code_d;
  logic                 ok_q, ok_d;
  // Unlock already seen while the last symbol was on the bus.
  logic                 early_q, early_d;

  logic                 cnt_load;
  logic [CW-1:0]        cnt_val;
  logic                 cnt_zero;
  sym_t                 cur_sym;

  cofre_tick_cnt #(.W(CW)) u_tick (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (cnt_val),
    .zero     (cnt_zero)
  );

  always_comb begin
    cur_sym = SYM_IDLE;
    for (int k = 0; k < SEQ_LEN; k++) begin
      if (idx_q == IW'(k)) cur_sym = code_q[2*k +: 2];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      code_q  <= '0;
      ok_q    <= 1'b0;
      early_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      code_q  <= code_d;
      ok_q    <= ok_d;
      early_q <= early_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    code_d   = code_q;
    ok_d     = ok_q;
    early_d  = early_q;
    cnt_load = 1'b0;
    cnt_val  = '0;
    x_out    = SYM_IDLE;
    busy     = 1'b0;
    done     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          code_d  = code_in;
          idx_d   = '0;
          ok_d    = 1'b0;
          early_d = 1'b0;
          state_d = ST_SEND;
        end
      end

      // A symbol is held for one cycle only: the lock steps on every
      // non-idle cycle it sees, so a repeat would count twice.
      ST_SEND: begin
        busy     = 1'b1;
        x_out    = cur_sym;
        // The lock's unlock output is Mealy on the final symbol.
        if ((idx_q == LAST) && y_in) early_d = 1'b1;
        cnt_load = 1'b1;
        cnt_val  = GAP_LOAD;
        state_d  = ST_GAP;
      end

      ST_GAP: begin
        busy = 1'b1;
        if (cnt_zero) begin
          if (idx_q == LAST) begin
            if (early_q) begin
              ok_d    = 1'b1;
              state_d = ST_DONE;
            end else begin
              cnt_load = 1'b1;
              cnt_val  = WAIT_LOAD;
              state_d  = ST_WAIT;
            end
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_SEND;
          end
        end
      end

      ST_WAIT: begin
        busy = 1'b1;
        if (y_in) begin
          ok_d    = 1'b1;
          state_d = ST_DONE;
        end else if (cnt_zero) begin
          ok_d    = 1'b0;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

`ifdef COFRE_CODE_TX_ABORT_EN
    // Abort wins over a same-cycle unlock and over normal sequencing.
    if (abort && ((state_q == ST_SEND) || (state_q == ST_GAP) ||
                  (state_q == ST_WAIT))) begin
      cnt_load = 1'b0;
      ok_d     = 1'b0;
      early_d  = 1'b0;
      state_d  = ST_DONE;
    end
`endif
  end

  assign ok        = ok_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_cofre_code_tx.sv
// Bench for cofre_code_tx: a default-parameter instance driven against a
// lock model, and a SEQ_LEN=2 / GAP_CYC=3 instance with the lock silent.
module tb_cofre_code_tx;
  import cofre_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DUT 1 (defaults) ----------------
  logic       start   = 1'b0;
  logic [9:0] code_in = '0;
  logic       y_force = 1'b0;
  logic       y_in;
  sym_t       x_out;
  logic       busy, done, ok;
  tx_state_t  st;
`ifdef COFRE_CODE_TX_ABORT_EN
  logic       abort  = 1'b0;
  logic       abort2 = 1'b0;
`endif

  cofre_code_tx u_dut (
    .clk       (clk),
    .rst       (rst),
`ifdef COFRE_CODE_TX_ABORT_EN
    .abort     (abort),
`endif
    .start     (start),
    .code_in   (code_in),
    .y_in      (y_in),
    .x_out     (x_out),
    .busy      (busy),
    .done      (done),
    .ok        (ok),
    .state_dbg (st)
  );

  // ---------------- DUT 2 (SEQ_LEN=2, GAP_CYC=3) ----------------
  logic       start2 = 1'b0;
  logic [3:0] code2  = '0;
  logic       y2     = 1'b0;
  sym_t       x2;
  logic       busy2, done2, ok2;
  tx_state_t  st2;

  cofre_code_tx #(.SEQ_LEN(2), .GAP_CYC(3), .TIMEOUT(8)) u_dut2 (
    .clk       (clk),
    .rst       (rst),
`ifdef COFRE_CODE_TX_ABORT_EN
    .abort     (abort2),
`endif
    .start     (start2),
    .code_in   (code2),
    .y_in      (y2),
    .x_out     (x2),
    .busy      (busy2),
    .done      (done2),
    .ok        (ok2),
    .state_dbg (st2)
  );

  // ---------------- lock model (A C A A B, Mealy unlock on final B) ----------------
  sym_t lock_seq [5] = '{SYM_A, SYM_C, SYM_A, SYM_A, SYM_B};
  int   lock_p;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      lock_p <= 0;
    end else if (done) begin
      lock_p <= 0;
    end else if (x_out != SYM_IDLE) begin
      if ((lock_p < 5) && (x_out == lock_seq[lock_p])) lock_p <= lock_p + 1;
      else if (x_out == lock_seq[0])                   lock_p <= 1;
      else                                             lock_p <= 0;
    end
  end

  assign y_in = y_force | ((lock_p == 4) && (x_out == SYM_B));

  // ---------------- scoreboard ----------------
  // Entry = {x_out[1:0], busy, done, ok} for one cycle.
  logic [4:0] exp_q[$];
  logic [4:0] exp2_q[$];
  logic       last_ok  = 1'b0;
  logic       last_ok2 = 1'b0;
  int         errors = 0;
  int         checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected per-cycle trace of one run, built from the protocol rules:
  // leading start cycle, per symbol one send cycle plus `gap` idle cycles,
  // then either an immediate result (unlocked on the last symbol), a wait
  // ended by a late unlock, or a full timeout. abort_at>0 cuts the run after
  // that cycle and finishes with ok=0.
  task automatic model_run(input int which, input int len, input int gap, input int tmo,
                           input logic [9:0] code, input bit unlocked, input int late,
                           input int abort_at);
    logic [4:0] t[$];
    logic [1:0] s;
    t.push_back({SYM_IDLE, 2'b00, (which == 1) ? last_ok : last_ok2});
    for (int k = 0; k < len; k++) begin
      s = code[2*k +: 2];
      t.push_back({s, 3'b100});
      for (int g = 0; g < gap; g++) t.push_back({SYM_IDLE, 3'b100});
    end
    if (unlocked) begin
      t.push_back({SYM_IDLE, 3'b011});
    end else if (late >= 0) begin
      for (int w = 0; w <= late; w++) t.push_back({SYM_IDLE, 3'b100});
      t.push_back({SYM_IDLE, 3'b011});
    end else begin
      for (int w = 0; w < tmo; w++) t.push_back({SYM_IDLE, 3'b100});
      t.push_back({SYM_IDLE, 3'b010});
    end
    if (abort_at > 0) begin
      while (t.size() > abort_at + 1) void'(t.pop_back());
      t.push_back({SYM_IDLE, 3'b010});
    end
    foreach (t[i]) begin
      if (which == 1) exp_q.push_back(t[i]);
      else            exp2_q.push_back(t[i]);
    end
  endtask

  // Single compare process: every cycle out of reset, both instances.
  always @(negedge clk) begin
    logic [4:0] e;
    logic [4:0] e2;
    if (rst) begin
      exp_q.delete();
      exp2_q.delete();
      last_ok  = 1'b0;
      last_ok2 = 1'b0;
    end else begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = {SYM_IDLE, 2'b00, last_ok};
      chk("trace1", {27'd0, x_out, busy, done, ok}, {27'd0, e});
      if (e[1]) last_ok = e[0];

      if (exp2_q.size() > 0) e2 = exp2_q.pop_front();
      else                   e2 = {SYM_IDLE, 2'b00, last_ok2};
      chk("trace2", {27'd0, x2, busy2, done2, ok2}, {27'd0, e2});
      if (e2[1]) last_ok2 = e2[0];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Issue a start on DUT 1; returns in cycle 1 of the run.
  task automatic run1(input logic [9:0] c, input int late, input int abort_at);
    code_in = c;
    start   = 1'b1;
    model_run(1, 5, 1, 8, c, (c == DEFAULT_CODE), late, abort_at);
    tick(1);
    start = 1'b0;
  endtask

  task automatic run2(input logic [3:0] c);
    code2  = c;
    start2 = 1'b1;
    model_run(2, 2, 3, 8, {6'd0, c}, 1'b0, -1, 0);
    tick(1);
    start2 = 1'b0;
  endtask

  sym_t t1_x [10] = '{SYM_A, SYM_IDLE, SYM_C, SYM_IDLE, SYM_A,
                      SYM_IDLE, SYM_A, SYM_IDLE, SYM_B, SYM_IDLE};

  // ---------------- directed sequence ----------------
  initial begin
    #2;
    chk("rst x_out", x_out, SYM_IDLE);
    chk("rst busy",  busy,  0);
    chk("rst done",  done,  0);
    chk("rst ok",    ok,    0);
    chk("rst state", st,    ST_IDLE);
    chk("rst x2",    x2,    SYM_IDLE);
    @(negedge clk);
    #1 rst = 1'b0;
    tick(2);

    // Default combination: early unlock, done at cycle 11.
    run1(DEFAULT_CODE, -1, 0);
    for (int c = 1; c <= 10; c++) begin
      chk($sformatf("t1 x_out c%0d", c), x_out, t1_x[c-1]);
      if (c == 9) chk("t1 y_in on final B", y_in, 1);
      tick(1);
    end
    chk("t1 done c11", done, 1);
    chk("t1 ok c11",   ok,   1);
    chk("t1 busy c11", busy, 0);
    tick(1);
    chk("t1 done c12", done, 0);
    chk("t1 ok held",  ok,   1);
    tick(3);

    // Wrong last symbol: timeout, done at cycle 19.
    run1(10'h15D, -1, 0);
    tick(10);
    chk("t2 x_out wait", x_out, SYM_IDLE);
    chk("t2 busy wait",  busy,  1);
    tick(7);
    chk("t2 done c18", done, 0);
    tick(1);
    chk("t2 done c19", done, 1);
    chk("t2 ok c19",   ok,   0);
    tick(3);

    // Starts during a run and on DONE are ignored; cycle 12 start is taken.
    run1(DEFAULT_CODE, -1, 0);
    tick(2);
    start   = 1'b1;
    code_in = 10'h0FF;
    tick(1);
    start = 1'b0;
    tick(7);
    start = 1'b1;
    chk("t3 done c11", done, 1);
    tick(1);
    code_in = 10'h15D;
    model_run(1, 5, 1, 8, 10'h15D, 1'b0, -1, 0);
    chk("t3 done c12", done, 0);
    tick(1);
    start = 1'b0;
    chk("t3 new run sym0", x_out, SYM_A);
    chk("t3 new run busy", busy, 1);
    tick(18);
    chk("t3 new run done", done, 1);
    chk("t3 new run ok",   ok,   0);
    tick(3);

    // Asynchronous reset in the middle of a gap.
    run1(DEFAULT_CODE, -1, 0);
    tick(5);
    #2 rst = 1'b1;
    #1;
    chk("t4 rst x_out", x_out, SYM_IDLE);
    chk("t4 rst busy",  busy,  0);
    chk("t4 rst done",  done,  0);
    chk("t4 rst state", st,    ST_IDLE);
    @(negedge clk);
    #1 rst = 1'b0;
    tick(2);
    run1(DEFAULT_CODE, -1, 0);
    chk("t4 replay sym0", x_out, SYM_A);
    tick(10);
    chk("t4 replay done", done, 1);
    chk("t4 replay ok",   ok,   1);
    tick(3);

    // Unlock seen in the third WAIT cycle: done at cycle 14 with ok=1.
    run1(10'h15D, 2, 0);
    tick(12);
    y_force = 1'b1;
    tick(1);
    y_force = 1'b0;
    chk("t6 late done", done, 1);
    chk("t6 late ok",   ok,   1);
    tick(3);

    // SEQ_LEN=2, GAP_CYC=3. Symbol 0 is the low bit pair of the code.
    run2(4'b1101);
    chk("t5a sym0", x2, SYM_A);
    tick(4);
    chk("t5a sym1", x2, SYM_C);
    tick(4);
    chk("t5a wait state", st2, ST_WAIT);
    tick(8);
    chk("t5a done", done2, 1);
    chk("t5a ok",   ok2,   0);
    tick(2);
    run2(4'b0111);
    chk("t5b sym0", x2, SYM_C);
    tick(3);
    chk("t5b gap end", x2, SYM_IDLE);
    tick(1);
    chk("t5b sym1", x2, SYM_A);
    tick(14);

`ifdef COFRE_CODE_TX_ABORT_EN
    // Abort during the third SEND: done with ok=0 in cycle 6.
    run1(DEFAULT_CODE, -1, 5);
    tick(4);
    abort = 1'b1;
    tick(1);
    abort = 1'b0;
    chk("t7 abort x_out", x_out, SYM_IDLE);
    chk("t7 abort done",  done,  1);
    chk("t7 abort ok",    ok,    0);
    tick(3);
`endif

    chk("trace1 drained", exp_q.size(), 0);
    chk("trace2 drained", exp2_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
